// File: rtl/ahblite_copy_master.sv
// Purpose : AHB-Lite initiator copying len_words 32-bit words from src_addr to dst_addr using single NONSEQ transfers.
// Latency : first NONSEQ one cycle after start; 4 cycles per copied word (2 per filled word); done pulses in the cycle after the last data phase.
// Backpress: HREADY=0 stalls the current address or data phase and holds every bus output; an error response aborts on its first cycle.
//
// Ports: HCLK/HRESETn clock and async active-low reset; start/src_addr/dst_addr/len_words/fill/fill_data command inputs
//        (sampled on start while idle); busy/done/error status; HADDR/HTRANS/HSIZE/HBURST/HPROT/HMASTLOCK/HWRITE/HWDATA
//        AHB-Lite master outputs; HRDATA/HREADY/HRESP slave responses.
// Optional feature: define AHB_COPY_FILL_EN to enable fill mode (write fill_data, skip reads). Undefined: fill inputs ignored.
module ahblite_copy_master (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] len_words,
    input  logic        fill,
    input  logic [31:0] fill_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_D,
        S_WR_A,
        S_WR_D,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Fill-mode plumbing. In the default build the mode is tied off and the
    // fill inputs are folded into an unused net so no logic is generated.
    logic        start_fill;
    logic        fill_mode;
`ifdef AHB_COPY_FILL_EN
    logic        fill_q, fill_d;

    assign start_fill = fill;
    assign fill_mode  = fill_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fill_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
        end
    end
`else
    logic        unused_fill;

    assign start_fill  = 1'b0;
    assign fill_mode   = 1'b0;
    assign unused_fill = &{1'b0, fill, fill_data};
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef AHB_COPY_FILL_EN
        fill_d  = fill_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (len_words != 16'd0) begin
                        src_d = {src_addr[31:2], 2'b00};
                        dst_d = {dst_addr[31:2], 2'b00};
                        cnt_d = len_words;
`ifdef AHB_COPY_FILL_EN
                        fill_d = fill;
                        // The data register doubles as the fill pattern
                        // holder; it is never overwritten in fill mode.
                        if (fill) begin
                            data_d = fill_data;
                        end
`endif
                        state_d = start_fill ? S_WR_A : S_RD_A;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_RD_A: begin
                if (HREADY) begin
                    state_d = S_RD_D;
                end
            end
            S_RD_D: begin
                // Abort on the first (HREADY=0) cycle of an error response.
                if (HRESP) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else if (HREADY) begin
                    data_d  = HRDATA;
                    src_d   = src_q + 32'd4;
                    state_d = S_WR_A;
                end
            end
            S_WR_A: begin
                if (HREADY) begin
                    state_d = S_WR_D;
                end
            end
            S_WR_D: begin
                if (HRESP) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else if (HREADY) begin
                    dst_d = dst_q + 32'd4;
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = fill_mode ? S_WR_A : S_RD_A;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs are registered from the next state so NONSEQ appears in
    // the first cycle of an address phase. HADDR/HWRITE hold through data
    // phases and idle so they only move when a new address phase begins.
    always_comb begin
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        htrans_d = TRANS_IDLE;
        if (state_d == S_RD_A) begin
            haddr_d  = src_d;
            hwrite_d = 1'b0;
            htrans_d = TRANS_NONSEQ;
        end else if (state_d == S_WR_A) begin
            haddr_d  = dst_d;
            hwrite_d = 1'b1;
            htrans_d = TRANS_NONSEQ;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            src_q    <= 32'd0;
            dst_q    <= 32'd0;
            cnt_q    <= 16'd0;
            data_q   <= 32'd0;
            err_q    <= 1'b0;
            haddr_q  <= 32'd0;
            htrans_q <= TRANS_IDLE;
            hwrite_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            err_q    <= err_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = err_q;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    // The data register is loaded before WR_A and untouched until the write
    // data phase ends, so it serves directly as the registered HWDATA.
    assign HWDATA    = data_q;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahblite_copy_master.sv
module tb_ahblite_copy_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len_words;
    logic        fill;
    logic [31:0] fill_data;
    logic        busy, done, error;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK, HWRITE;
    logic [31:0] HWDATA, HRDATA;
    logic        HREADY, HRESP;

    always #5 HCLK = ~HCLK;

    ahblite_copy_master dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len_words(len_words), .fill(fill), .fill_data(fill_data),
        .busy(busy), .done(done), .error(error), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;
    xfer_t exp_q[$];

    // Slave configuration, set by the stimulus before each command.
    int n_waits     = 0;
    int err_rd_idx  = -1;
    int rd_idx      = 0;
    int nonseq_cnt  = 0;

    // Slave data-phase state.
    logic        dp_active = 1'b0;
    logic        dp_wr, dp_err, err_seen, dp_first;
    logic [31:0] dp_addr, dp_wdata;
    int          waits_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] d);
        xfer_t e;
        e.wr = wr; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0011;
            32'h0000_0004: return 32'h0000_0022;
            32'h0000_0008: return 32'h0000_0033;
            32'hFFFF_FFFC: return 32'hCAFE_0000;
            default:       return 32'hBAD0_BAD0;
        endcase
    endfunction

    // Compares a finished (or error-terminated) data phase with the head of the expected queue.
    task automatic pop_cmp(input logic chk_data);
        xfer_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_xfer_addr", dp_addr, 32'hxxxx_xxxx);
        end else begin
            e = exp_q.pop_front();
            chk("xfer_write", {31'd0, dp_wr}, {31'd0, e.wr});
            chk("xfer_addr", dp_addr, e.addr);
            if (chk_data && dp_wr) chk("xfer_wdata", HWDATA, e.data);
        end
    endtask

    // Slave model and monitor: decides HREADY/HRESP for the current cycle
    // at the falling edge, when DUT outputs are stable.
    always @(negedge HCLK) begin
        logic rdy, rsp;
        rdy = 1'b1;
        rsp = 1'b0;
        if (!HRESETn) begin
            dp_active = 1'b0;
        end else begin
            if (dp_active) begin
                if (dp_first) begin
                    dp_wdata = HWDATA;
                    dp_first = 1'b0;
                end
                if (dp_err) begin
                    rsp = 1'b1;
                    if (!err_seen) begin
                        rdy = 1'b0;
                        err_seen = 1'b1;
                        pop_cmp(1'b0);
                    end else begin
                        dp_active = 1'b0;
                    end
                end else if (waits_left > 0) begin
                    rdy = 1'b0;
                    waits_left--;
                    chk("stall_haddr", HADDR, dp_addr);
                    if (dp_wr) chk("stall_hwdata", HWDATA, dp_wdata);
                end else begin
                    if (!dp_wr) HRDATA = mem_rd(dp_addr);
                    pop_cmp(1'b1);
                    dp_active = 1'b0;
                end
            end
            if (!dp_active && rdy && HTRANS == 2'b10) begin
                dp_active  = 1'b1;
                dp_first   = 1'b1;
                dp_addr    = HADDR;
                dp_wr      = HWRITE;
                dp_err     = !HWRITE && (rd_idx == err_rd_idx);
                err_seen   = 1'b0;
                waits_left = n_waits;
                if (!HWRITE) rd_idx++;
                nonseq_cnt++;
            end
        end
        HREADY = rdy;
        HRESP  = rsp;
    end

    // Issues one command, optionally pulses a second start at cycle mid_cyc,
    // then checks done timing, error, pulse width and issued transfer count.
    task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                           input logic f, input logic [31:0] fd, input int exp_done,
                           input logic exp_err, input int exp_ns, input int mid_cyc);
        int got;
        got = 0;
        @(negedge HCLK);
        nonseq_cnt = 0;
        rd_idx     = 0;
        start = 1'b1; src_addr = s; dst_addr = d; len_words = n; fill = f; fill_data = fd;
        @(posedge HCLK);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge HCLK);
            if (cyc == 1) chk("busy_after_start", {31'd0, busy}, 32'd1);
            if (cyc == mid_cyc) begin
                start = 1'b1; src_addr = 32'h0000_0100; dst_addr = 32'h5000_0000; len_words = 16'd5;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                got = cyc;
                break;
            end
        end
        start = 1'b0;
        chk("done_cycle", got, exp_done);
        chk("error_flag", {31'd0, error}, {31'd0, exp_err});
        @(negedge HCLK);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_cleared", {31'd0, busy}, 32'd0);
        chk("nonseq_count", nonseq_cnt, exp_ns);
        chk("exp_queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        HRESETn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
        fill = 1'b0; fill_data = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (3) @(negedge HCLK);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_status", {29'd0, busy, done, error}, 32'd0);
        chk("rst_hsize", {29'd0, HSIZE}, 32'd2);
        chk("rst_hburst", {29'd0, HBURST}, 32'd0);
        chk("rst_hprot", {28'd0, HPROT}, 32'd3);
        chk("rst_hmastlock", {31'd0, HMASTLOCK}, 32'd0);
        HRESETn = 1'b1;

        // Zero-wait copy of three words.
        push(0, 32'h0, 0); push(1, 32'h2000_0000, 32'h11);
        push(0, 32'h4, 0); push(1, 32'h2000_0004, 32'h22);
        push(0, 32'h8, 0); push(1, 32'h2000_0008, 32'h33);
        run_cmd(32'h0, 32'h2000_0000, 16'd3, 1'b0, 32'h0, 13, 1'b0, 6, 0);

        // Same copy with two wait states per data phase: 6 phases x 2 later.
        n_waits = 2;
        push(0, 32'h0, 0); push(1, 32'h2000_0000, 32'h11);
        push(0, 32'h4, 0); push(1, 32'h2000_0004, 32'h22);
        push(0, 32'h8, 0); push(1, 32'h2000_0008, 32'h33);
        run_cmd(32'h0, 32'h2000_0000, 16'd3, 1'b0, 32'h0, 25, 1'b0, 6, 0);
        n_waits = 0;

        // Zero-length command: no transfers, FIN right after start.
        run_cmd(32'h0, 32'h2000_0000, 16'd0, 1'b0, 32'h0, 1, 1'b0, 0, 0);

        // Error response on the second read aborts after one write.
        err_rd_idx = 1;
        push(0, 32'h0, 0); push(1, 32'h2000_0000, 32'h11); push(0, 32'h4, 0);
        run_cmd(32'h0, 32'h2000_0000, 16'd3, 1'b0, 32'h0, 7, 1'b1, 3, 0);
        err_rd_idx = -1;
        // Next accepted start clears the sticky error.
        run_cmd(32'h0, 32'h0, 16'd0, 1'b0, 32'h0, 1, 1'b0, 0, 0);

        // Address wrap plus a start pulse during WR_A that must be ignored;
        // low destination bits are dropped.
        push(0, 32'hFFFF_FFFC, 0); push(1, 32'h3000_0000, 32'hCAFE_0000);
        push(0, 32'h0000_0000, 0); push(1, 32'h3000_0004, 32'h11);
        run_cmd(32'hFFFF_FFFC, 32'h3000_0003, 16'd2, 1'b0, 32'h0, 9, 1'b0, 4, 3);

`ifdef AHB_COPY_FILL_EN
        // Fill mode: writes only, two cycles per word.
        push(1, 32'h4000_0000, 32'hDEAD_BEEF); push(1, 32'h4000_0004, 32'hDEAD_BEEF);
        push(1, 32'h4000_0008, 32'hDEAD_BEEF); push(1, 32'h4000_000C, 32'hDEAD_BEEF);
        run_cmd(32'h0, 32'h4000_0000, 16'd4, 1'b1, 32'hDEAD_BEEF, 9, 1'b0, 4, 0);
`else
        // Without the fill feature, fill=1 still performs a normal copy.
        push(0, 32'h8, 0); push(1, 32'h4000_0000, 32'h33);
        run_cmd(32'h8, 32'h4000_0000, 16'd1, 1'b1, 32'hDEAD_BEEF, 5, 1'b0, 2, 0);
`endif

        // Async reset while the first write address phase is on the bus.
        begin
            logic seen;
            seen = 1'b0;
            push(0, 32'h0, 0);
            @(negedge HCLK);
            start = 1'b1; src_addr = 32'h0; dst_addr = 32'h2000_0000; len_words = 16'd2; fill = 1'b0;
            @(posedge HCLK);
            #1 start = 1'b0;
            for (int cyc = 0; cyc < 20; cyc++) begin
                @(negedge HCLK);
                if (HTRANS == 2'b10 && HWRITE) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("reached_wr_a", {31'd0, seen}, 32'd1);
            #2 HRESETn = 1'b0;
            #1;
            chk("arst_htrans", {30'd0, HTRANS}, 32'd0);
            chk("arst_busy", {31'd0, busy}, 32'd0);
            chk("arst_haddr", HADDR, 32'd0);
            chk("arst_done_err", {30'd0, done, error}, 32'd0);
            exp_q.delete();
            @(negedge HCLK);
            @(negedge HCLK);
            HRESETn = 1'b1;
            nonseq_cnt = 0;
            repeat (4) @(negedge HCLK);
            chk("post_rst_idle", {30'd0, busy, done}, 32'd0);
            chk("post_rst_nonseq", nonseq_cnt, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
